// File: rtl/twi_pkg.sv
// rtl/twi_pkg.sv - shared types, constants and sizing helper for the TWI SCL phase generator
package twi_pkg;

  typedef enum logic [2:0] {
    SCL_IDLE,
    SCL_LOW_A,
    SCL_LOW_B,
    SCL_HIGH_A,
    SCL_HIGH_B
  } scl_phase_e;

  localparam int HALF_BASE_DEF = 8;

  // Wide enough for HALF_BASE + max twbr shifted by the largest prescaler (4^(2^w-1)).
  function automatic int cnt_width(input int twbr_w, input int twps_w);
    return twbr_w + 2 * ((1 << twps_w) - 1) + 1;
  endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - generic clear/increment counter
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/twi_scl_phase_generator.sv
// rtl/twi_scl_phase_generator.sv - four-phase SCL timing engine; TWI_SCL_STRETCH_EN enables slave clock stretching
module twi_scl_phase_generator
  import twi_pkg::*;
#(
  parameter int TWBR_WIDTH = 8,
  parameter int TWPS_WIDTH = 2,
  parameter int HALF_BASE  = HALF_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  scl_gen_en,
  input  logic [TWPS_WIDTH-1:0] twps,
  input  logic [TWBR_WIDTH-1:0] twbr,
  input  logic                  scl_in,
  output logic                  scl_out,
  output logic                  scl_fall_stb,
  output logic                  drive_stb,
  output logic                  scl_rise_stb,
  output logic                  sample_stb,
  output logic                  busy,
  output logic                  stretching
);

  localparam int CNT_WIDTH = cnt_width(TWBR_WIDTH, TWPS_WIDTH);

  scl_phase_e            state;
  logic [TWBR_WIDTH-1:0] twbr_sh;
  logic [TWPS_WIDTH-1:0] twps_sh;
  logic [CNT_WIDTH-1:0]  half;
  logic [CNT_WIDTH-1:0]  q1;
  logic [CNT_WIDTH-1:0]  q2;
  logic [CNT_WIDTH-1:0]  phase_len;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  stall;
  logic                  inc;
  logic                  clear;
  logic                  expire;

`ifdef TWI_SCL_STRETCH_EN
  assign stall = (state == SCL_HIGH_A) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  // Shift amount is twps*2, widened by one bit so the largest prescaler does not wrap.
  assign half      = CNT_WIDTH'(HALF_BASE) + (CNT_WIDTH'(twbr_sh) << {twps_sh, 1'b0});
  assign q1        = half >> 1;
  assign q2        = half - q1;
  assign phase_len = (state == SCL_LOW_A || state == SCL_HIGH_A) ? q1 : q2;
  assign inc       = busy && !stall;
  assign expire    = inc && (cnt == phase_len - CNT_WIDTH'(1));
  assign clear     = expire || (state == SCL_IDLE);

  counter #(
    .WIDTH(CNT_WIDTH)
  ) u_phase_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .inc    (inc),
    .count  (cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= SCL_IDLE;
      twbr_sh      <= '0;
      twps_sh      <= '0;
      scl_out      <= 1'b1;
      busy         <= 1'b0;
      stretching   <= 1'b0;
      scl_fall_stb <= 1'b0;
      drive_stb    <= 1'b0;
      scl_rise_stb <= 1'b0;
      sample_stb   <= 1'b0;
    end else begin
      scl_fall_stb <= 1'b0;
      drive_stb    <= 1'b0;
      scl_rise_stb <= 1'b0;
      sample_stb   <= 1'b0;
      stretching   <= stall;
      case (state)
        SCL_IDLE: begin
          if (scl_gen_en) begin
            state        <= SCL_LOW_A;
            twbr_sh      <= twbr;
            twps_sh      <= twps;
            scl_out      <= 1'b0;
            busy         <= 1'b1;
            scl_fall_stb <= 1'b1;
          end
        end
        SCL_LOW_A: begin
          if (expire) begin
            state     <= SCL_LOW_B;
            drive_stb <= 1'b1;
          end
        end
        SCL_LOW_B: begin
          if (expire) begin
            state        <= SCL_HIGH_A;
            scl_out      <= 1'b1;
            scl_rise_stb <= 1'b1;
          end
        end
        SCL_HIGH_A: begin
          if (expire) begin
            state      <= SCL_HIGH_B;
            sample_stb <= 1'b1;
          end
        end
        SCL_HIGH_B: begin
          // Enable is only consulted at the period boundary, so stops never truncate a period.
          if (expire) begin
            if (scl_gen_en) begin
              state        <= SCL_LOW_A;
              twbr_sh      <= twbr;
              twps_sh      <= twps;
              scl_out      <= 1'b0;
              scl_fall_stb <= 1'b1;
            end else begin
              state <= SCL_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= SCL_IDLE;
          scl_out <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/twi_scl_phase_generator.md
# twi_scl_phase_generator

Four-phase SCL timing engine for the TWI master, generalising the half-period tick generator. From the TWBR/TWPS bit-rate settings it produces the SCL drive level and one-cycle phase strobes (fall, drive, rise, sample) that the byte/bit controller uses to change SDA mid-low and sample SDA mid-high. It sits between the register block (twbr, twps, enable) and the bit-level FSM. It supports graceful stop at a period boundary and, optionally, slave clock stretching.

## Interface
- TWBR_WIDTH, 8: width of the bit-rate register.
- TWPS_WIDTH, 2: width of the prescaler field; the prescaler multiplies by 4^twps.
- HALF_BASE, 8: fixed part of the half period, in clk cycles (SCL period = 2*HALF_BASE + 2*twbr*4^twps).
- clk  in  1  system clock. Single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- scl_gen_en  in  1  level enable. Rise starts generation; fall requests a stop at the next period end.
- twps  in  TWPS_WIDTH  prescaler select.
- twbr  in  TWBR_WIDTH  bit-rate divider.
- scl_in  in  1  synchronised bus SCL level. Used only for stretching.
- scl_out  out  1  SCL drive level (0 = pull low, 1 = release).
- scl_fall_stb  out  1  pulse in the first cycle of LOW_A.
- drive_stb  out  1  pulse in the first cycle of LOW_B (SDA change point).
- scl_rise_stb  out  1  pulse in the first cycle of HIGH_A.
- sample_stb  out  1  pulse in the first cycle of HIGH_B (SDA sample point).
- busy  out  1  high in any state other than IDLE.
- stretching  out  1  high while HIGH_A is held by a low scl_in.

## Operation
**Arithmetic**
- CNT_WIDTH = TWBR_WIDTH + 2*(2^TWPS_WIDTH − 1) + 1, so the maximum half period never overflows.
- H = HALF_BASE + (twbr << (twps << 1)), computed at CNT_WIDTH.
- Phase lengths: Q1 = H >> 1 and Q2 = H − Q1.
- Phase durations: LOW_A and HIGH_A last Q1 cycles; LOW_B and HIGH_B last Q2 cycles.
- twbr and twps are latched into shadow registers on every entry to LOW_A. Register changes made mid-period take effect at the next period.

**State machine** (states IDLE, LOW_A, LOW_B, HIGH_A, HIGH_B)
- IDLE → LOW_A when scl_gen_en = 1.
- LOW_A → LOW_B → HIGH_A → HIGH_B on phase-count expiry. The counter clears at count = len−1.
- HIGH_B → LOW_A on expiry if scl_gen_en = 1, otherwise HIGH_B → IDLE.
- scl_out is 0 in LOW_A and LOW_B, and 1 in every other state.
- Strobes are registered and mutually exclusive; exactly one fires per phase entry.

**Boundary conditions**
- Deasserting scl_gen_en mid-period completes the period through HIGH_B with no truncation.
- Reasserting scl_gen_en before HIGH_B expires continues without a gap.
- twbr = 0, twps = 0 is the minimum: H = 8, Q1 = Q2 = 4, period 16.
- Maximum twbr and twps must not wrap.
- Asserting resetn low mid-operation forces IDLE immediately and clears all outputs to their reset values.

## Timing
- Reset values:
  - scl_out = 1.
  - busy, stretching and all strobes = 0.
  - State IDLE, counter 0.
- Start latency: scl_gen_en sampled high in IDLE at edge t gives scl_out = 0, scl_fall_stb = 1 and busy = 1 from edge t+1.
- Period without stretching: exactly 2H clk cycles. Each strobe repeats every 2H cycles.
- Stop: busy falls in the cycle after HIGH_B's last cycle.
- Stretch (macro enabled): the HIGH_A counter does not advance while scl_in = 0.
  - stretching rises one cycle after the first cycle in which scl_in is low in HIGH_A.
  - scl_rise_stb still fires on HIGH_A entry.
  - Q1 counting starts in the first cycle with scl_in = 1.

## Configuration
- TWI_SCL_STRETCH_EN defined: the stretch behaviour above is active.
- TWI_SCL_STRETCH_EN undefined:
  - scl_in is ignored and the port is kept for interface stability.
  - stretching is tied to 0.
  - The period is always exactly 2H.

## Structure
- twi_pkg holds:
  - the state enum scl_phase_e.
  - HALF_BASE default constant.
  - a function computing CNT_WIDTH from TWBR_WIDTH and TWPS_WIDTH.
- Sub-module: the team's generic `counter` (clear/inc, parameterised width) serves as the phase counter.
  - inc = busy and not stalled.
  - clear = phase expiry or IDLE.

## Test plan
- **Minimum divisor:** twbr = 0, twps = 0, enable held high. Strobes at offsets 0/4/8/12 within each 16-cycle period; scl_out low for 8 cycles, high for 8.
- **Odd split:** twbr = 3, twps = 0. H = 11, Q1 = 5, Q2 = 6, period 22; drive_stb 5 cycles after scl_fall_stb.
- **Prescaler and mid-period update:** twbr = 10, twps = 1 gives period 96. Changing twbr to 0 mid-period gives period 16 starting only at the next LOW_A.
- **Graceful stop and reset:**
  - Drop scl_gen_en in LOW_B: the period completes, busy falls after HIGH_B and scl_out = 1.
  - Pulse resetn mid-HIGH_A: IDLE immediately and all outputs at reset values.
- **Stretch (TWI_SCL_STRETCH_EN):** hold scl_in low for 20 cycles after HIGH_A entry. stretching is high for those 20 cycles, the period extends by exactly 20, and sample_stb is delayed by 20.
- **Maximum settings:** twbr = 255, twps = 3. H = 8 + 16320 = 16328 and period 32656 with no counter wrap.
